// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Shared PRBS7 definitions: sequence length, recurrence taps,
//                checker state encoding and the default generator seed.
//  Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

  // Recurrence b[n] = b[n-7] ^ b[n-6] (x^7 + x^6 + 1).
  // The history holds b[n-7] at index 0 and b[n-6] at index 1.
  localparam int PRBS7_LEN   = 7;
  localparam int PRBS7_TAP_A = 0;
  localparam int PRBS7_TAP_B = 1;

  // Bit 0 of the seed is the first bit emitted on the line.
  localparam logic [PRBS7_LEN-1:0] PRBS7_SEED = 7'b1101100;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

endpackage
`default_nettype wire

// File: rtl/prbs7_predict.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_predict
//  Description : PRBS7 history register and next-bit predictor. While
//                searching, received bits are shifted in; once locked, the
//                predictor feeds back its own prediction and free-runs.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset (clears history)
//                adv  - advance the history by one bit
//                load - 1: shift in din, 0: shift in the prediction
//                din  - received bit
//                hist - current 7-bit history (index 0 = oldest)
//                p    - predicted value of the next bit
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs7_predict
  import prbs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 load,
  input  logic                 din,
  output logic [PRBS7_LEN-1:0] hist,
  output logic                 p
);

  always_comb begin
    p = hist[PRBS7_TAP_A] ^ hist[PRBS7_TAP_B];
  end

  // Newest bit enters at the top, the oldest falls off index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else if (adv) begin
      hist <= {(load ? din : p), hist[PRBS7_LEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/prbs7_chk.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_chk
//  Description : Serial PRBS7 checker. Self-synchronises to the incoming
//                stream, declares lock after LOCK_CNT consecutive correct
//                predictions, then checks every valid bit against a
//                free-running predictor and keeps saturating BER counters.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous active-high reset
//                din       - received serial bit
//                din_valid - din is sampled only when 1
//                clr_cnt   - synchronous clear of err_count / bit_count
//                locked    - checker is in the LOCKED state
//                err       - one-cycle pulse per mismatched bit while locked
//                err_count - saturating error count while locked
//                bit_count - saturating checked-bit count while locked
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs7_chk
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_ERRS = 4,
  parameter int UNLOCK_WIN  = 64,
  parameter int ERR_CNT_W   = 16,
  parameter int BIT_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [BIT_CNT_W-1:0] bit_count
);

  localparam int FILL_W = $clog2(PRBS7_LEN + 1);
  localparam int MC_W   = $clog2(LOCK_CNT + 1);
  localparam int WE_W   = $clog2(UNLOCK_ERRS + 1);
  localparam int WB_W   = $clog2(UNLOCK_WIN + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PRBS7_LEN);
  localparam logic [MC_W-1:0]   MC_LAST   = MC_W'(LOCK_CNT - 1);
  localparam logic [WE_W-1:0]   WE_LAST   = WE_W'(UNLOCK_ERRS - 1);
  localparam logic [WB_W-1:0]   WB_LAST   = WB_W'(UNLOCK_WIN - 1);

  prbs_state_t           state;
  prbs_state_t           state_nxt;
  logic [FILL_W-1:0]     fill;
  logic [MC_W-1:0]       match_cnt;
  logic [WE_W-1:0]       win_err;
  logic [WB_W-1:0]       win_bits;
  logic [PRBS7_LEN-1:0]  hist;
  logic                  p;

  logic in_search;
  logic filled;
  logic match;
  logic lock_hit;
  logic lk_bit;
  logic mism;
  logic unlock_hit;
  logic win_wrap;

  prbs7_predict u_pred (
    .clk  (clk),
    .rst  (rst),
    .adv  (din_valid),
    .load (in_search),
    .din  (din),
    .hist (hist),
    .p    (p)
  );

  always_comb begin
    in_search  = (state == SEARCH);
    filled     = (fill == FILL_FULL);
    // An all-zero history predicts zero forever; it must never build lock.
    match      = din_valid & in_search & filled & (din == p) & (hist != '0);
    lock_hit   = match & (match_cnt == MC_LAST);
    lk_bit     = din_valid & ~in_search;
    mism       = lk_bit & (din ^ p);
    unlock_hit = mism & (win_err == WE_LAST);
    win_wrap   = lk_bit & (win_bits == WB_LAST);
  end

  // ---------------- state machine: register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- state machine: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (lock_hit)   state_nxt = LOCKED;
      LOCKED:  if (unlock_hit) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // ---------------- state machine: outputs ----------------
  always_comb begin
    locked = (state == LOCKED);
  end

  // Acquisition and unlock-window bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_err   <= '0;
    end else if (din_valid) begin
      if (in_search) begin
        if (!filled) begin
          fill <= fill + 1'b1;
        end else if (match) begin
          match_cnt <= lock_hit ? '0 : match_cnt + 1'b1;
        end else begin
          match_cnt <= '0;
        end
      end else if (unlock_hit) begin
        // Dropping lock wins over a window restart on the same bit; the
        // cleared fill forces a complete refill from the line.
        fill      <= '0;
        match_cnt <= '0;
        win_bits  <= '0;
        win_err   <= '0;
      end else if (win_wrap) begin
        win_bits <= '0;
        win_err  <= '0;
      end else begin
        win_bits <= win_bits + 1'b1;
        win_err  <= win_err + WE_W'(mism);
      end
    end
  end

  // Error pulse and BER counters; counters only move while locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err <= mism;
      if (clr_cnt) begin
        err_count <= '0;
        bit_count <= '0;
      end else begin
        if (lk_bit && (bit_count != '1)) bit_count <= bit_count + 1'b1;
        if (mism && (err_count != '1))   err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs7_chk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs7_chk
//  Description : Self-checking bench for prbs7_chk. A sequence-level model
//                of the checker (bit queues and plain counters) is stepped
//                alongside the DUT; directed scenarios add explicit checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs7_chk;
  import prbs_pkg::*;

  localparam int LOCK_CNT    = 16;
  localparam int UNLOCK_ERRS = 4;
  localparam int UNLOCK_WIN  = 64;
  localparam int ERR_CNT_W   = 16;
  localparam int BIT_CNT_W   = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 din = 1'b0;
  logic                 din_valid = 1'b0;
  logic                 clr_cnt = 1'b0;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;
  logic [BIT_CNT_W-1:0] bit_count;

  always #5 clk = ~clk;

  prbs7_chk #(
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_ERRS (UNLOCK_ERRS),
    .UNLOCK_WIN  (UNLOCK_WIN),
    .ERR_CNT_W   (ERR_CNT_W),
    .BIT_CNT_W   (BIT_CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  // ---------------- reference model ----------------
  bit     m_hist[$];   // last 7 bits as seen by the predictor, [0] oldest
  int     m_fill, m_match, m_wb, m_we;
  bit     m_locked, m_err;
  longint m_ec, m_bc;

  // ---------------- PRBS7 stream source ----------------
  bit         g[$];
  logic [6:0] g_seed;

  task automatic gen_reset(input logic [6:0] seed);
    g.delete();
    g_seed = seed;
  endtask

  task automatic gen_next(output bit b);
    int n;
    n = g.size();
    if (n < 7) b = g_seed[n];
    else       b = g[n-7] ^ g[n-6];
    g.push_back(b);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit v, input bit d, input bit c, input bit r);
    bit pred;
    bit hz;
    if (r) begin
      m_hist.delete();
      repeat (7) m_hist.push_back(1'b0);
      m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
      m_locked = 0; m_err = 0; m_ec = 0; m_bc = 0;
      return;
    end
    m_err = 0;
    if (v) begin
      pred = m_hist[0] ^ m_hist[1];
      hz = 1'b1;
      foreach (m_hist[i]) if (m_hist[i]) hz = 1'b0;
      if (!m_locked) begin
        if (m_fill < 7) m_fill++;
        else if (d == pred && !hz) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_locked = 1;
            m_match  = 0;
          end
        end else m_match = 0;
        m_hist.push_back(d);
      end else begin
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (d != pred) begin
          m_err = 1;
          if (m_ec < 65535) m_ec++;
          m_we++;
        end
        m_wb++;
        if (m_we == UNLOCK_ERRS) begin
          m_locked = 0; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
        end else if (m_wb == UNLOCK_WIN) begin
          m_wb = 0; m_we = 0;
        end
        m_hist.push_back(pred);
      end
      void'(m_hist.pop_front());
    end
    if (c) begin
      m_ec = 0;
      m_bc = 0;
    end
  endtask

  // One clock: drive, clock, sample 1 ns after the edge, compare to model.
  task automatic step(input bit v, input bit d, input bit c, input bit r);
    din_valid = v;
    din       = d;
    clr_cnt   = c;
    rst       = r;
    @(posedge clk);
    #1;
    model_step(v, d, c, r);
    if (err === 1'b1) err_pulses++;
    check("locked",    {63'd0, locked}, {63'd0, m_locked});
    check("err",       {63'd0, err},    {63'd0, m_err});
    check("err_count", {48'd0, err_count}, m_ec);
    check("bit_count", {32'd0, bit_count}, m_bc);
  endtask

  task automatic step_prbs(input bit flip, input bit clr);
    bit b;
    gen_next(b);
    step(1'b1, b ^ flip, clr, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    int lock_at;
    int n;
    int vcount;
    int pos[4];
    bit flip;
    bit v;

    // ---- 1: continuous lock from the shared seed ----
    gen_reset(PRBS7_SEED);
    do_reset();
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_err_count", {48'd0, err_count}, 64'd0);
    lock_at = 0;
    err_pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      step_prbs(1'b0, 1'b0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    check("s1_lock_at", lock_at, 64'd23);
    check("s1_err_pulses", err_pulses, 64'd0);
    check("s1_bit_count", {32'd0, bit_count}, 64'd177);
    check("s1_err_count", {48'd0, err_count}, 64'd0);

    // ---- 2: single bit error while locked ----
    err_pulses = 0;
    n = $urandom_range(5, 30);
    for (int i = 0; i < 40; i++) step_prbs(i == n, 1'b0);
    check("s2_err_pulses", err_pulses, 64'd1);
    check("s2_err_count", {48'd0, err_count}, 64'd1);
    check("s2_locked", {63'd0, locked}, 64'd1);

    // ---- 3: all-zero input never locks ----
    do_reset();
    err_pulses = 0;
    for (int i = 0; i < 150; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("s3_locked", {63'd0, locked}, 64'd0);
    check("s3_err_pulses", err_pulses, 64'd0);
    check("s3_bit_count", {32'd0, bit_count}, 64'd0);

    // ---- 4: loss of lock and relock, random seed and error spacing ----
    gen_reset(7'($urandom_range(1, 127)));
    do_reset();
    for (int i = 0; i < 30; i++) step_prbs(1'b0, 1'b0);
    check("s4_locked_initial", {63'd0, locked}, 64'd1);
    pos[0] = $urandom_range(0, 9);
    for (int j = 1; j < 4; j++) pos[j] = pos[j-1] + $urandom_range(1, 10);
    for (int i = 0; i <= pos[3]; i++) begin
      if (i == pos[3]) check("s4_locked_before_4th", {63'd0, locked}, 64'd1);
      flip = (i == pos[0]) || (i == pos[1]) || (i == pos[2]) || (i == pos[3]);
      step_prbs(flip, 1'b0);
    end
    check("s4_unlocked", {63'd0, locked}, 64'd0);
    check("s4_err_count", {48'd0, err_count}, 64'd4);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step_prbs(1'b0, 1'b0);
      n++;
      if (locked === 1'b1) break;
    end
    check("s4_relock_bits", n, 64'd23);

    // ---- random traffic: gaps, sparse errors, occasional clears ----
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) step_prbs($urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
      else   step(1'b0, 1'($urandom), $urandom_range(0, 99) == 0, 1'b0);
    end

    // ---- 5: valid gaps with garbage on invalid cycles ----
    gen_reset(PRBS7_SEED);
    do_reset();
    lock_at = 0;
    vcount = 0;
    err_pulses = 0;
    while (vcount < 200) begin
      step_prbs(1'b0, 1'b0);
      vcount++;
      if (locked === 1'b1 && lock_at == 0) lock_at = vcount;
      step(1'b0, 1'($urandom), 1'b0, 1'b0);
    end
    check("s5_lock_at", lock_at, 64'd23);
    check("s5_err_pulses", err_pulses, 64'd0);
    check("s5_bit_count", {32'd0, bit_count}, 64'd177);

    // ---- 6: clear beats increment, reset beats everything ----
    step_prbs(1'b1, 1'b1);
    check("s6_err_pulse", {63'd0, err}, 64'd1);
    check("s6_err_count_cleared", {48'd0, err_count}, 64'd0);
    check("s6_bit_count_cleared", {32'd0, bit_count}, 64'd0);
    for (int i = 0; i < 5; i++) step_prbs(1'b0, 1'b0);
    check("s6_bit_count_after", {32'd0, bit_count}, 64'd5);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("s6_rst_locked", {63'd0, locked}, 64'd0);
    check("s6_rst_err_count", {48'd0, err_count}, 64'd0);
    check("s6_rst_bit_count", {32'd0, bit_count}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs7_chk.md
Name: prbs7_chk

Overview:
- Serial PRBS7 checker; the receive-side counterpart to the PRBS7 generator. Polynomial is x^7 + x^6 + 1, with bit recurrence b[n] = b[n-7] XOR b[n-6].
- Self-synchronises to the incoming bit stream, declares lock, and then checks each bit against a locally free-running predictor.
- Reports per-bit errors plus saturating error and bit counters for BER measurement on loopback/link test benches.

Parameters:
- LOCK_CNT, 16: consecutive correct predictions required to declare lock.
- UNLOCK_ERRS, 4: errors within one window that force loss of lock.
- UNLOCK_WIN, 64: window length in valid bits for the unlock criterion.
- ERR_CNT_W, 16: width of err_count.
- BIT_CNT_W, 32: width of bit_count.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, 1: received serial bit.
- din_valid, input, 1: din is sampled only when this is 1.
- clr_cnt, input, 1: synchronous clear of err_count and bit_count.
- locked, output, 1: checker is in the LOCKED state.
- err, output, 1: one-cycle pulse on a mismatched bit while locked.
- err_count, output, ERR_CNT_W: saturating count of errors seen while locked.
- bit_count, output, BIT_CNT_W: saturating count of valid bits checked while locked.

Behaviour:
- Reset: rst=1 at a clk edge sets the following, and takes priority over everything:
  - state = SEARCH; hist = 0; fill = 0; match_cnt = 0; window counters = 0.
  - locked = 0, err = 0, err_count = 0, bit_count = 0.
  - Reset asserted mid-lock behaves identically.
- History register:
  - hist[6:0]; hist[0] is the oldest bit (b[n-7]) and hist[1] is b[n-6].
  - Prediction p = hist[0] XOR hist[1].
  - Updated only on cycles with din_valid=1. Cycles with din_valid=0 change nothing except that err returns to 0.
- SEARCH state, per valid bit:
  - Always hist <= {din, hist[6:1]}.
  - If fill < 7: fill++ and no compare is made.
  - Otherwise, if din == p and hist != 0: match_cnt++. If not, match_cnt = 0.
  - The all-zero history never counts toward lock, so an all-zero stream must never lock.
  - On the LOCK_CNT-th consecutive match, go to LOCKED; locked = 1 from the next cycle.
  - Minimum lock time is 7 + LOCK_CNT valid bits (23 by default).
- LOCKED state, per valid bit:
  - Compare din against p.
  - hist <= {p, hist[6:1]}: the predictor free-runs and din is not fed back, so one line error yields exactly one err pulse, not three.
  - bit_count++, saturating at all-ones.
  - On mismatch:
    - err = 1 for exactly one cycle, registered the cycle after the sampling edge.
    - err_count++, saturating at all-ones.
    - win_err++.
  - win_bits++ on every valid bit. When win_bits reaches UNLOCK_WIN, both win_bits and win_err restart at 0.
- Unlock:
  - When win_err reaches UNLOCK_ERRS, go to SEARCH the same edge the error is recorded; locked = 0 on the next cycle.
  - fill, match_cnt and the window counters clear. hist keeps its value but fill = 0 forces a full 7-bit refill.
  - The unlock check takes priority over a window restart on the same bit.
- Counters:
  - clr_cnt=1 clears err_count and bit_count, and takes priority over a simultaneous increment.
  - err still pulses on that cycle. State and lock are unaffected.
  - Counters hold their values through SEARCH; they increment only while locked.
- Latency:
  - err, err_count and bit_count reflect a bit one clk after its valid sampling edge.
  - locked reflects a transition one clk after the deciding bit.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS7_LEN = 7 and the tap positions (0 and 1).
  - The state enum {SEARCH, LOCKED}.
  - The default seed 7'b1101100, so generator and checker benches share it.
- One natural sub-module: prbs7_predict, holding hist, the load/free-run mux and p. The state machine and counters stay in prbs7_chk.

Test Plan:
1. Continuous lock:
   - Stimulus: reset; drive 200 valid bits of generator output from seed 1101100 (stream starts 0,0,1,1,0,...).
   - Response: locked rises the cycle after bit 23; err never pulses; err_count = 0; bit_count = 177.
2. Single bit error:
   - Stimulus: after lock, invert one bit.
   - Response: exactly one err pulse, one cycle after that bit; err_count = 1; locked stays 1.
3. All-zero input:
   - Stimulus: 150 valid bits of 0 after reset.
   - Response: locked stays 0, err = 0, counters stay 0.
4. Loss of lock:
   - Stimulus: after lock, invert 4 bits within a 64-bit window.
   - Response: locked falls the cycle after the 4th error; err_count = 4. Continuing clean PRBS relocks exactly 23 valid bits later.
5. Valid gaps:
   - Stimulus: repeat scenario 1 with din_valid alternating 1/0, driving garbage on din during invalid cycles.
   - Response: lock after the 23rd valid bit; err never pulses.
6. Clear and reset priority:
   - Stimulus: assert clr_cnt on the same cycle an error is recorded; then assert rst while locked.
   - Response: err pulses but err_count = 0; after rst, locked = 0 and both counters = 0 on the next cycle.
